// File: rtl/tff_count_ctrl_if.sv
// Control/observation bundle for the T-flip-flop count controller.
// The requester drives the run request; the controller reports the bank.
interface tff_count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             up;
  logic [WIDTH-1:0] limit;
  logic             pause;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output start, up, limit, pause,
    input  t_vec, q, busy, done
  );

  modport slave (
    input  start, up, limit, pause,
    output t_vec, q, busy, done
  );
endinterface

// File: rtl/tff_count_ctrl.sv
// Bounded up/down counter built from a T-flip-flop bank.
// The bank only ever sees q <= q ^ t_vec; the FSM shapes t_vec.
module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  tff_count_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] end_r;
  logic [WIDTH-1:0] init;
  logic [WIDTH-1:0] inc_tog;
  logic [WIDTH-1:0] dec_tog;
  logic             dir_r;
  logic             busy_r;
  logic             done_r;
  logic             all_one;
  logic             all_zero;
  logic             at_end;

  assign init   = bus.up ? '0 : bus.limit;
  assign at_end = (q == end_r);

  // Bit i toggles when every lower bit is 1 (increment) or 0 (decrement).
  always_comb begin
    inc_tog  = '0;
    dec_tog  = '0;
    all_one  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      inc_tog[i] = all_one;
      dec_tog[i] = all_zero;
      all_one    = all_one & q[i];
      all_zero   = all_zero & ~q[i];
    end
  end

  always_comb begin
    t_vec     = '0;
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          t_vec     = q ^ init;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (at_end) begin
          state_nxt = DONE;
        end else if (bus.pause) begin
          state_nxt = HOLD;
        end else begin
          t_vec = dir_r ? inc_tog : dec_tog;
        end
      end
      HOLD: begin
        if (!bus.pause) state_nxt = RUN;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      q      <= '0;
      dir_r  <= 1'b0;
      end_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q ^ t_vec;
      busy_r <= (state_nxt == RUN) || (state_nxt == HOLD);
      done_r <= (state_nxt == DONE);
      if (state == IDLE && bus.start) begin
        dir_r <= bus.up;
        end_r <= bus.up ? bus.limit : '0;
      end
    end
  end

  assign bus.t_vec = t_vec;
  assign bus.q     = q;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Scoreboard bench: a cycle-level reference model queues expected outputs,
// a negedge monitor pops and compares them against the controller.
module tb_tff_count_ctrl;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HOLD = 2;
  localparam int S_DONE = 3;

  typedef struct {
    int    q;
    bit    busy;
    bit    done;
    int    tv;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tff_count_ctrl_if #(.WIDTH(W)) bus ();

  tff_count_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t sbq[$];
  int   errors   = 0;
  int   checks   = 0;
  int   exp_done = 0;
  int   act_done = 0;
  int   m_ph, m_q, m_dir, m_end;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) act_done++;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.tag, ".q"},     32'(bus.q),     32'(e.q));
      chk({e.tag, ".busy"},  32'(bus.busy),  32'(e.busy));
      chk({e.tag, ".done"},  32'(bus.done),  32'(e.done));
      chk({e.tag, ".t_vec"}, 32'(bus.t_vec), 32'(e.tv));
    end
  end

  // One clock of stimulus; the model works with plain integer counts.
  task automatic step(bit rst, bit st, bit u, int lim, bit p, string tag);
    exp_t e;
    int nq, nph, ndir, nend;
    reset     = rst;
    bus.start = st;
    bus.up    = u;
    bus.limit = lim[W-1:0];
    bus.pause = p;
    nq   = m_q;
    nph  = m_ph;
    ndir = m_dir;
    nend = m_end;
    case (m_ph)
      S_IDLE: if (st) begin
        nq   = u ? 0 : lim;
        ndir = u;
        nend = u ? lim : 0;
        nph  = S_RUN;
      end
      S_RUN: begin
        if (m_q == m_end) nph = S_DONE;
        else if (p) nph = S_HOLD;
        else nq = m_dir ? m_q + 1 : m_q - 1;
      end
      S_HOLD: if (!p) nph = S_RUN;
      default: nph = S_IDLE;
    endcase
    e.q    = m_q;
    e.busy = (m_ph == S_RUN) || (m_ph == S_HOLD);
    e.done = (m_ph == S_DONE);
    e.tv   = (m_q ^ nq) & MASK;
    e.tag  = tag;
    if (e.done) exp_done++;
    sbq.push_back(e);
    if (rst) begin
      nq = 0; nph = S_IDLE; ndir = 0; nend = 0;
    end
    @(posedge clk);
    #1;
    m_q = nq; m_ph = nph; m_dir = ndir; m_end = nend;
  endtask

  task automatic finish_run(string tag);
    int n = 0;
    while (m_ph != S_IDLE && n < 100) begin
      step(0, 0, 0, 0, 0, tag);
      n++;
    end
    checks++;
    if (m_ph != S_IDLE) begin
      errors++;
      $display("FAIL %s.timeout: still busy after %0d cycles", tag, n);
    end
  endtask

  task automatic run(bit u, int lim, string tag);
    step(0, 1, u, lim, 0, tag);
    finish_run(tag);
  endtask

  initial begin
    int cnt;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.up    = 1'b0;
    bus.limit = '0;
    bus.pause = 1'b0;
    @(posedge clk);
    #1;
    m_ph = S_IDLE; m_q = 0; m_dir = 0; m_end = 0;

    step(1, 0, 0, 0, 0, "reset");
    step(0, 0, 0, 0, 0, "idle");
    run(1, 3, "up3");
    run(0, 5, "down5");

    step(0, 1, 1, 6, 0, "pause");
    while (m_q != 2) step(0, 0, 0, 0, 0, "pause");
    repeat (3) step(0, 0, 0, 0, 1, "pause.hold");
    finish_run("pause");

    run(1, 0, "lim0");

    step(0, 1, 1, 15, 0, "up15");
    while (m_q != 5) step(0, 0, 0, 0, 0, "up15");
    step(0, 1, 0, 2, 0, "up15.restart");
    finish_run("up15");

    step(0, 1, 1, 10, 0, "abort");
    while (m_q != 6) step(0, 0, 0, 0, 0, "abort");
    step(1, 0, 0, 0, 0, "abort.reset");
    step(0, 0, 0, 0, 0, "abort.idle");
    run(1, 2, "after_abort");

    repeat (40) begin
      step(0, 1, 1'($urandom_range(0, 1)), $urandom_range(0, MASK), 0, "rnd");
      cnt = 0;
      while (m_ph != S_IDLE && cnt < 200) begin
        step(($urandom_range(0, 59) == 0),
             ($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)),
             $urandom_range(0, MASK),
             ($urandom_range(0, 4) == 0),
             "rnd");
        cnt++;
      end
      repeat ($urandom_range(0, 2)) step(0, 0, 0, 0, 0, "rnd.idle");
    end

    @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(sbq.size()), 32'd0);
    chk("done_count", 32'(act_done), 32'(exp_done));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
